// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the processor's memory control stage and the responder.
// Handshake: the master presents req & en with rw/addbus/databus; the slave samples them only in an
// accepting state, and signals completion with a one-cycle ready (rdata/err valid with it).
interface data_memory_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              en;
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addbus;
  logic [DATA_W-1:0] databus;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output en, req, rw, addbus, databus,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  en, req, rw, addbus, databus,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed RAM responder: captures a request, waits WAIT_CYCLES, performs the access,
// then pulses ready for one cycle. Out-of-range addresses complete with err instead of aliasing.
module data_memory_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_responder_if.slave bus,
  output logic [1:0]             dbg_state
);
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              cap_rw;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              in_range;
  logic              access;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Full-width compare so addresses beyond the RAM are flagged rather than wrapped.
  assign in_range = ({1'b0, cap_addr} < MEM_LIMIT);
  assign idx      = cap_addr[IDX_W-1:0];
  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign mem_we   = access && !cap_rw && in_range;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RESP: state_n = (bus.req && bus.en) ? WAIT : IDLE;
      WAIT:       state_n = (cnt == 4'd0) ? RESP : WAIT;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_rw   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (bus.req && bus.en) begin
            cap_rw   <= bus.rw;
            cap_addr <= bus.addbus;
            cap_data <= bus.databus;
            cnt      <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!in_range) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cap_rw) begin
            rdata_q <= mem[idx];
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is not reset; a reset mid-transfer drops state to IDLE so mem_we never fires.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= cap_data;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == RESP);
  assign bus.busy  = (state == WAIT);
  assign bus.err   = err_q;
  assign dbg_state = state;
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the processor's data-memory bus: it accepts the load/store requests the memory control stage drives on `addbus`/`databus`/`rw`/`en` and completes them against an internal word-addressed RAM after a programmable number of wait states. Read data is returned on `rdata` with a one-cycle `ready` completion pulse, so the processor can retire LDR/STR operations. Out-of-range addresses are flagged instead of aliased.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 16, address bus width (word address)
- `MEM_WORDS`, 1024, implemented RAM depth in words (≤ 2^ADDR_W)
- `WAIT_CYCLES`, 2, wait states inserted before each access completes (0..15)

- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-low reset
- `en` input 1 — chip enable; requests ignored while low
- `req` input 1 — request strobe; a transfer starts when `req & en` is sampled in an accepting state
- `rw` input 1 — 1 = read, 0 = write; sampled with the request
- `addbus` input ADDR_W — word address; sampled with the request
- `databus` input DATA_W — write data; sampled with the request
- `rdata` output DATA_W — read data; valid while `ready` is high, held afterwards
- `ready` output 1 — one-cycle completion pulse for every accepted request
- `busy` output 1 — high while a request is in flight (states WAIT)
- `err` output 1 — high with `ready` when the captured address ≥ MEM_WORDS

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- Accepting states: IDLE and RESP. On an edge in an accepting state with `req & en`: capture `rw`, `addbus`, `databus` into internal registers, load wait counter with WAIT_CYCLES, go to WAIT. Otherwise go/stay IDLE.
- WAIT: if counter ≠ 0, decrement and stay. If counter = 0, perform the access at this edge and go to RESP.
  - Read, in range: `rdata` ← mem[addr].
  - Write, in range: mem[addr] ← captured data; `rdata` unchanged.
  - Out of range (either direction): no RAM write, `rdata` ← 0, `err` ← 1.
- RESP: `ready` = 1, `busy` = 0 for exactly this cycle; a new request may be accepted here (back-to-back).
- Requests presented while in WAIT are ignored (no queueing); the initiator must hold or re-present `req` until an accepting state.
- Inputs change freely after capture; only captured values are used.
- Read of a location written by the immediately preceding request returns the new data (write lands before the next access).
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: `rdata` = 0, `ready` = 0, `busy` = 0, `err` = 0, counter = 0, state IDLE.
- Reset asserted mid-transfer: state to IDLE immediately; a pending write is discarded (RAM untouched); no `ready` pulse.
- Latency: request accepted at edge E0 → `ready` high in the cycle after edge E0 + WAIT_CYCLES + 1, low after the following edge unless another completion follows.
- WAIT_CYCLES = 0: `ready` in the cycle after E1.
- Max throughput with `req` held: one completion every WAIT_CYCLES + 2 cycles.
- `busy` high from the cycle after E0 until the edge entering RESP.
- `err` only ever high in the same cycle as `ready`.
- `en` low in an accepting state: treated as no request.
- Address width: only ADDR_W bits compared against MEM_WORDS; no wrap-around or aliasing.

## Test plan
- Reset with `req=1,en=1` held, release → first `ready` exactly WAIT_CYCLES+2 cycles after the first accepting edge; all outputs 0 during reset.
- Write 0xDEADBEEF to addr 5, then read addr 5 (WAIT_CYCLES=2) → second `ready` with `rdata`=0xDEADBEEF, `err`=0, each `ready` one cycle wide, `busy` high 3 cycles per access.
- Back-to-back with `req` held: write addr 7 = 0x12345678 immediately followed by read addr 7 → read returns 0x12345678; completions spaced 4 cycles apart.
- Read and write at addr 1024 (MEM_WORDS=1024) → `ready` and `err` both pulse, `rdata`=0, subsequent read of addr 0 unchanged.
- Start write addr 3 = 0xAAAA5555 (addr 3 previously 0x11111111), assert reset during WAIT → no `ready`; after release, read addr 3 returns 0x11111111.
- Toggle `addbus`/`databus`/`rw` and pulse `req` during WAIT → ignored; completed access uses values captured at E0.
